riscv_lsu: RTL
==============

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have these ports: clk_i, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have: rst_ni, input, 1, asynchronous active-low reset.
REQ-003 SHALL have: core_req_i, input, 1, core memory-access request.
REQ-004 SHALL have: core_we_i, input, 1, 1 = store, 0 = load.
REQ-005 SHALL have: core_size_i, input, 3, access type (funct3 encoding): 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
REQ-006 SHALL have: core_addr_i, input, 32, byte address.
REQ-007 SHALL have: core_wd_i, input, 32, store data, right-aligned.
REQ-008 SHALL have: core_rd_o, output, 32, load result, extended.
REQ-009 SHALL have: core_stall_o, output, 1, core must hold all inputs while this is 1.
REQ-010 SHALL have: misalign_o, output, 1, misaligned-access pulse (tied 0 unless REQ-030 applies).
REQ-011 SHALL have: mem_req_o, output, 1, memory request.
REQ-012 SHALL have: mem_we_o, output, 1, memory write enable.
REQ-013 SHALL have: mem_be_o, output, 4, memory byte enables.
REQ-014 SHALL have: mem_addr_o, output, 32, memory address.
REQ-015 SHALL have: mem_wd_o, output, 32, memory write data.
REQ-016 SHALL have: mem_rd_i, input, 32, memory read data (valid one cycle after request).
REQ-017 SHALL have: mem_ready_i, input, 1, memory completion flag.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and WAIT: IDLE to WAIT when core_req_i is 1 and the access is not trapped; WAIT to IDLE when mem_ready_i is 1 or core_req_i is 0.
REQ-019 SHALL drive core_stall_o = core_req_i AND NOT (state == WAIT AND mem_ready_i), forced to 0 for a trapped access.
REQ-020 SHALL drive mem_req_o = core_req_i (trapped accesses excluded), mem_we_o = core_we_i, and mem_addr_o = core_addr_i, all combinationally.
REQ-021 SHALL give every access a minimum latency of 2 cycles: request cycle with stall = 1, then a WAIT cycle; completion happens in the first WAIT cycle with mem_ready_i = 1.
REQ-022 SHALL generate mem_be_o by size: B gives 4'b0001 << addr[1:0]; H gives 4'b0011 << (2·addr[1]); W gives 4'b1111; any other size gives 4'b0000.
REQ-023 SHALL drive mem_wd_o by size: B replicates wd[7:0] four times; H replicates wd[15:0] twice; otherwise wd unchanged.
REQ-024 SHALL select the load lane by size: B and BU take byte addr[1:0]; H and HU take halfword addr[1]; W takes the full word.
REQ-025 SHALL extend loads as follows: B and H sign-extend; BU and HU zero-extend; sizes 3, 6 and 7 return 0.
REQ-026 SHALL drive core_rd_o combinationally from mem_rd_i; it is valid only in the completion cycle of a load, and 0 at all other times.
REQ-027 SHALL abort when core_req_i drops during WAIT: go to IDLE, drop mem_req_o, no completion.
REQ-028 SHALL start the next request in the cycle directly after completion (back-to-back) without any idle cycle.

Reset
REQ-029 SHALL, while rst_ni = 0 and regardless of clock, force state to IDLE, which de-asserts the stall term from WAIT; on reset during WAIT the pending access is dropped and restarts from IDLE after release.

Configuration
REQ-030 SHALL, when macro LSU_MISALIGN_TRAP_EN is defined, trap H/HU with addr[0] = 1 and W with addr[1:0] != 0: mem_req_o = 0, core_stall_o = 0, misalign_o = 1 for that cycle only, state stays IDLE.
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, hold misalign_o at 0, ignore addr[0] for H/HU, ignore addr[1:0] for W, and issue the access normally.

Verification
REQ-032 SHALL cover: store W, addr 0x10, wd 0xCAFEBABE, ready in 2nd cycle -> be 1111, wd 0xCAFEBABE, stall 1 then 0.
REQ-033 SHALL cover: store B, addr 0x13, wd 0x000000A5 -> be 1000, mem_wd_o 0xA5A5A5A5.
REQ-034 SHALL cover: load B at addr 0x22 with mem_rd_i 0x1280FF00 -> core_rd_o 0xFFFFFF80; same access as BU -> 0x00000080; HU at addr 0x22 -> 0x00001280.
REQ-035 SHALL cover: ready held 0 for 3 WAIT cycles, then 1 -> stall high for 4 cycles, drops in the ready cycle, FSM returns to IDLE.
REQ-036 SHALL cover: rst_ni asserted mid-WAIT -> state IDLE immediately; after release with a new request -> fresh 2-cycle access.
REQ-037 SHALL cover: load W at addr 0x06 -> with LSU_MISALIGN_TRAP_EN: misalign_o 1 for one cycle, mem_req_o 0, stall 0; without it: normal access to word 0x04.

Source files
------------

// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu -- load/store unit between a RISC-V core and a simple memory port.
//
// A two-state FSM (IDLE, WAIT) sequences each access. Every access takes at
// least two cycles: the request cycle (always stalled) and one or more WAIT
// cycles. The access completes in the first WAIT cycle that sees mem_ready_i.
// Byte enables and replicated store data are derived from the access size.
// Load data is lane-selected and extended from mem_rd_i, and it is valid only
// in the completion cycle.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned H/HU/W
// accesses. A trapped access pulses misalign_o, is never issued to memory and
// does not stall. In the default build misaligned accesses are issued as if
// the low address bits were clear, and misalign_o is held at 0.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   core_req_i      core access request; core holds inputs while core_stall_o
//   core_we_i       1 = store, 0 = load
//   core_size_i     funct3 size: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   core_addr_i     byte address
//   core_wd_i       right-aligned store data
//   core_rd_o       extended load result, 0 outside a load completion cycle
//   core_stall_o    core must hold its request
//   misalign_o      misaligned-access pulse (trap build only)
//   mem_req_o/we_o/be_o/addr_o/wd_o   memory request port
//   mem_rd_i        memory read data
//   mem_ready_i     memory completion flag
// -----------------------------------------------------------------------------
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e state;
    logic   trapped;
    logic   in_wait;
    logic   complete;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        misaligned = 1'b0;
        case (core_size_i)
            SZ_H, SZ_HU: misaligned = core_addr_i[0];
            SZ_W:        misaligned = |core_addr_i[1:0];
            default:     misaligned = 1'b0;
        endcase
    end

    assign trapped = core_req_i & misaligned;
`else
    assign trapped = 1'b0;
`endif

    assign in_wait  = (state == S_WAIT);
    assign complete = in_wait & mem_ready_i & core_req_i;

    // Request side is purely combinational; a trapped access never reaches memory.
    assign misalign_o   = trapped;
    assign mem_req_o    = core_req_i & ~trapped;
    assign mem_we_o     = core_we_i;
    assign mem_addr_o   = core_addr_i;
    assign core_stall_o = core_req_i & ~(in_wait & mem_ready_i) & ~trapped;

    // Byte enables and store data. Unsigned sizes share the lane layout of
    // their signed counterparts; sizes 3, 6 and 7 enable no bytes.
    always_comb begin
        mem_be_o = 4'b0000;
        mem_wd_o = core_wd_i;
        case (core_size_i)
            SZ_B, SZ_BU: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            SZ_H, SZ_HU: begin
                mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            SZ_W:    mem_be_o = 4'b1111;
            default: mem_be_o = 4'b0000;
        endcase
    end

    // Load lane select and extension. In the default build addr[0] is not
    // looked at for halfwords and addr[1:0] not at all for words.
    always_comb begin
        rd_byte = mem_rd_i[{core_addr_i[1:0], 3'b000} +: 8];
        rd_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        rd_ext  = 32'h0;
        case (core_size_i)
            SZ_B:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
            SZ_BU:   rd_ext = {24'h0, rd_byte};
            SZ_H:    rd_ext = {{16{rd_half[15]}}, rd_half};
            SZ_HU:   rd_ext = {16'h0, rd_half};
            SZ_W:    rd_ext = mem_rd_i;
            default: rd_ext = 32'h0;
        endcase
    end

    assign core_rd_o = (complete & ~core_we_i) ? rd_ext : 32'h0;

    // A dropped request in WAIT aborts the access; the cycle after a completion
    // is IDLE, which can already accept the next request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (core_req_i && !trapped)        state <= S_WAIT;
                S_WAIT:  if (mem_ready_i || !core_req_i)    state <= S_IDLE;
                default:                                     state <= S_IDLE;
            endcase
        end
    end

endmodule
